// File: rtl/filter_sample_capture_pkg.sv
// Shared definitions for the filter sample capture sink and its sibling filter blocks.
`timescale 1ns/1ps
package filter_sample_capture_pkg;

  localparam int SAMPLE_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/filter_sample_capture_ram_sp.sv
// Simple dual-port sample store: one write port, one registered read port (block-RAM friendly).
`timescale 1ns/1ps
module capture_ram_sp
  import filter_sample_capture_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/filter_sample_capture.sv
// Capture sink: after arm, skips skip_len valid samples, stores DEPTH samples, then drains them in order.
`timescale 1ns/1ps
module filter_sample_capture
  import filter_sample_capture_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_W,
  parameter int DEPTH  = 2048,
  parameter int SKIP_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [SKIP_W-1:0] skip_len,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              sample_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       count
);

  cap_state_e        state_r, state_next_s;
  logic [SKIP_W-1:0] skip_cnt_r;
  logic [AW:0]       count_r;   // low bits double as the write pointer
  logic [AW:0]       rd_cnt_r;  // reads issued to the RAM
  logic [AW:0]       tx_cnt_r;  // beats handed to the consumer
  logic              ram_vld_r;
  logic [WIDTH-1:0]  ram_rdata_s;
  logic [WIDTH-1:0]  rd_data_r;
  logic              rd_valid_r, busy_r, done_r;
  logic              we_s, arm_go_s, out_load_s, xfer_s, ram_re_s, last_xfer_s;

  assign arm_go_s    = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign out_load_s  = !rd_valid_r || rd_ready;
  assign xfer_s      = rd_valid_r && rd_ready;
  assign last_xfer_s = xfer_s && (tx_cnt_r == (AW+1)'(DEPTH - 1));
  // A read is only issued when the RAM output slot is free or being consumed this cycle.
  assign ram_re_s    = (state_r == ST_DRAIN) && !rd_cnt_r[AW] && (!ram_vld_r || out_load_s);

  // Next-state decode and capture write strobe.
  always_comb begin
    state_next_s = state_r;
    we_s         = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_next_s = (skip_len == {SKIP_W{1'b0}}) ? ST_CAPTURE : ST_SKIP;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_SKIP: begin
        if (sample_valid && (skip_cnt_r == SKIP_W'(1))) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_SKIP;
        end
      end
      ST_CAPTURE: begin
        if (sample_valid) begin
          we_s = 1'b1;
          if (count_r == (AW+1)'(DEPTH - 1)) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_CAPTURE;
          end
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (last_xfer_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, status flags and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      skip_cnt_r <= {SKIP_W{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      rd_cnt_r   <= {(AW+1){1'b0}};
      tx_cnt_r   <= {(AW+1){1'b0}};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_SKIP) || (state_next_s == ST_CAPTURE) ||
                 (state_next_s == ST_DRAIN);
      done_r  <= (state_next_s == ST_DONE);
      if (arm_go_s) begin
        skip_cnt_r <= skip_len;
        count_r    <= {(AW+1){1'b0}};
        rd_cnt_r   <= {(AW+1){1'b0}};
        tx_cnt_r   <= {(AW+1){1'b0}};
      end else begin
        if ((state_r == ST_SKIP) && sample_valid) begin
          skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
        end
        if (we_s) begin
          count_r <= count_r + (AW+1)'(1);
        end
        if (ram_re_s) begin
          rd_cnt_r <= rd_cnt_r + (AW+1)'(1);
        end
        if (xfer_s) begin
          tx_cnt_r <= tx_cnt_r + (AW+1)'(1);
        end
      end
    end
  end

  // Two-stage read pipeline: RAM output slot, then the presented prefetch register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_vld_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else if (state_r != ST_DRAIN) begin
      ram_vld_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      if (ram_re_s) begin
        ram_vld_r <= 1'b1;
      end else if (out_load_s) begin
        ram_vld_r <= 1'b0;
      end
      if (last_xfer_s) begin
        rd_valid_r <= 1'b0;
      end else if (out_load_s) begin
        rd_valid_r <= ram_vld_r;
        rd_data_r  <= ram_rdata_s;
      end
    end
  end

  capture_ram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (count_r[AW-1:0]),
    .wdata (sample_in),
    .re    (ram_re_s),
    .raddr (rd_cnt_r[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;

endmodule
